// File: rtl/conway_pkg.sv
// Shared constants and types for the Conway frame scan-out path.
// Grid geometry, cell word type and the scan FSM encoding.
package conway_pkg;

  localparam int unsigned WORD_BITS     = 20;
  localparam int unsigned WORDS_PER_ROW = 64;
  localparam int unsigned ROWS          = 1024;
  localparam int unsigned FRAME_WORDS   = WORDS_PER_ROW * ROWS;
  localparam int unsigned FRAME_CELLS   = FRAME_WORDS * WORD_BITS;

  typedef logic [WORD_BITS-1:0] cell_word_t;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDrain
  } scan_state_t;

endpackage

// File: rtl/scan_fifo.sv
// Synchronous prefetch FIFO of cell words with flush, count, empty and full.
// DEPTH must be a power of two so the pointers wrap naturally.
module scan_fifo
  import conway_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  input  logic                   i_flush,
  input  logic                   i_push,
  input  cell_word_t             i_data,
  input  logic                   i_pop,
  output cell_word_t             o_data,
  output logic                   o_empty,
  output logic                   o_full,
  output logic [$clog2(DEPTH):0] o_count
);

  localparam int unsigned PtrBits = $clog2(DEPTH);

  logic [PtrBits-1:0] r_wr_ptr;
  logic [PtrBits-1:0] r_rd_ptr;
  logic [PtrBits:0]   r_count;
  cell_word_t         r_mem [DEPTH];
  logic               w_push;
  logic               w_pop;

  assign w_pop  = i_pop && (r_count != '0);
  // A push into a full FIFO is only legal when a pop frees the slot this cycle.
  assign w_push = i_push && ((r_count != (PtrBits + 1)'(DEPTH)) || w_pop);

  always_ff @(posedge i_clk) begin
    if (!i_reset || i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PtrBits'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PtrBits'(1);
      r_count <= r_count + (PtrBits + 1)'(w_push) - (PtrBits + 1)'(w_pop);
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_data;
  end

  assign o_data  = r_mem[r_rd_ptr];
  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == (PtrBits + 1)'(DEPTH));
  assign o_count = r_count;

  a_no_overflow: assert property (@(posedge i_clk) disable iff (!i_reset)
    !(i_push && !i_flush && o_full && !i_pop));

endmodule

// File: rtl/cell_scanout.sv
// Display-side frame reader: fetches cell words over the B port, buffers them
// and serializes one cell (MSB first) per VGA pixel request.
module cell_scanout
  import conway_pkg::*;
#(
  parameter int unsigned ROW_WORDS    = WORDS_PER_ROW,
  parameter int unsigned GRID_ROWS    = ROWS,
  parameter int unsigned ADDR_BITS    = 16,
  parameter int unsigned FIFO_DEPTH   = 4,
  parameter int unsigned READ_LATENCY = 2
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_frame_start,
  input  logic                 i_pixel_req,
  output logic                 o_pixel_out,
  output logic                 o_pixel_valid,
  output logic                 o_underflow,
  output logic                 o_frame_done,
  output logic [ADDR_BITS-1:0] o_address_b,
  output logic                 o_read_b,
  input  cell_word_t           i_q_b,
  input  logic                 i_wait_request
);

  localparam int unsigned FrameWords  = ROW_WORDS * GRID_ROWS;
  localparam int unsigned FrameCells  = FrameWords * WORD_BITS;
  localparam int unsigned CntBits     = $clog2(FrameCells + 1);
  localparam int unsigned IdxBits     = $clog2(WORD_BITS);
  localparam int unsigned FifoCntBits = $clog2(FIFO_DEPTH) + 1;

  scan_state_t             r_state;
  scan_state_t             w_state_next;
  logic [ADDR_BITS-1:0]    r_addr;
  logic [READ_LATENCY-1:0] r_tag;
  cell_word_t              r_ser_word;
  logic [IdxBits-1:0]      r_ser_idx;
  logic                    r_ser_valid;
  logic [CntBits-1:0]      r_cell_cnt;
  logic                    r_pix_out;
  logic                    r_pix_valid;
  logic                    r_underflow;
  logic                    r_last;
  logic                    r_frame_done;

  int unsigned             w_inflight;
  logic [FifoCntBits-1:0]  w_fifo_count;
  logic                    w_fifo_empty;
  logic                    w_fifo_full;
  cell_word_t              w_fifo_head;
  logic                    w_read;
  logic                    w_accept;
  logic                    w_last_addr;
  logic                    w_push;
  logic                    w_pop;
  logic                    w_cells_done;
  logic                    w_service;
  logic                    w_avail;
  logic                    w_emit;
  logic                    w_last_cell;
  cell_word_t              w_cur_word;
  logic [IdxBits-1:0]      w_cur_idx;

  scan_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_flush (i_frame_start),
    .i_push  (w_push),
    .i_data  (i_q_b),
    .i_pop   (w_pop),
    .o_data  (w_fifo_head),
    .o_empty (w_fifo_empty),
    .o_full  (w_fifo_full),
    .o_count (w_fifo_count)
  );

  always_comb begin
    w_inflight = 0;
    for (int i = 0; i < READ_LATENCY; i++) w_inflight += 32'(r_tag[i]);
  end

  assign w_last_addr = (r_addr == ADDR_BITS'(FrameWords - 1));
  assign w_read      = (r_state == StRun) && !i_frame_start &&
                       (32'(w_fifo_count) + w_inflight + 1 <= FIFO_DEPTH);
  assign w_accept    = w_read && !i_wait_request;
  assign w_push      = r_tag[READ_LATENCY-1] && !i_frame_start;

  // Once every cell is out, further requests are ignored until the next frame.
  assign w_cells_done = (r_cell_cnt == CntBits'(FrameCells));
  assign w_service    = i_pixel_req && !i_frame_start && (r_state != StIdle) && !w_cells_done;
  assign w_avail      = r_ser_valid || !w_fifo_empty;
  assign w_emit       = w_service && w_avail;
  assign w_cur_word   = r_ser_valid ? r_ser_word : w_fifo_head;
  assign w_cur_idx    = r_ser_valid ? r_ser_idx : IdxBits'(WORD_BITS - 1);
  // An empty serializer emits straight from the FIFO head, so there is never a bubble.
  assign w_pop        = w_emit && !w_fifo_empty && (!r_ser_valid || (r_ser_idx == '0));
  assign w_last_cell  = w_emit && (r_cell_cnt == CntBits'(FrameCells - 1));

  always_ff @(posedge i_clk) begin
    if (!i_reset) r_state <= StIdle;
    else          r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    if (i_frame_start) begin
      w_state_next = StRun;
    end else begin
      unique case (r_state)
        StIdle:  w_state_next = StIdle;
        StRun:   if (w_accept && w_last_addr) w_state_next = StDrain;
        StDrain: if (r_frame_done) w_state_next = StIdle;
        default: w_state_next = StIdle;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset || i_frame_start) begin
      r_addr       <= '0;
      r_tag        <= '0;
      r_ser_word   <= '0;
      r_ser_idx    <= '0;
      r_ser_valid  <= 1'b0;
      r_cell_cnt   <= '0;
      r_pix_out    <= 1'b0;
      r_pix_valid  <= 1'b0;
      r_underflow  <= 1'b0;
      r_last       <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      if (w_accept && !w_last_addr) r_addr <= r_addr + ADDR_BITS'(1);
      r_tag[0] <= w_accept;
      for (int i = 1; i < READ_LATENCY; i++) r_tag[i] <= r_tag[i-1];

      if (w_emit) begin
        if (!r_ser_valid) begin
          r_ser_word  <= w_fifo_head;
          r_ser_idx   <= IdxBits'(WORD_BITS - 2);
          r_ser_valid <= 1'b1;
        end else if (r_ser_idx == '0) begin
          r_ser_word  <= w_fifo_head;
          r_ser_idx   <= IdxBits'(WORD_BITS - 1);
          r_ser_valid <= !w_fifo_empty;
        end else begin
          r_ser_idx <= r_ser_idx - IdxBits'(1);
        end
        r_cell_cnt <= r_cell_cnt + CntBits'(1);
      end

      r_pix_valid  <= w_service;
      r_pix_out    <= w_emit && w_cur_word[w_cur_idx];
      if (w_service && !w_avail) r_underflow <= 1'b1;
      r_last       <= w_last_cell;
      r_frame_done <= r_last;
    end
  end

  assign o_pixel_out   = r_pix_out;
  assign o_pixel_valid = r_pix_valid;
  assign o_underflow   = r_underflow;
  assign o_frame_done  = r_frame_done;
  assign o_address_b   = r_addr;
  assign o_read_b      = w_read;

endmodule

// File: tb/tb_cell_scanout.sv
// Bench for cell_scanout on a reduced 8x4-word grid: directed corner sequences
// plus table-driven randomized frames checked against a cell-stream model.
module tb_cell_scanout;
  import conway_pkg::*;

  localparam int unsigned RowWords   = 8;
  localparam int unsigned GridRows   = 4;
  localparam int unsigned FrameWords = RowWords * GridRows;
  localparam int unsigned FrameCells = FrameWords * WORD_BITS;
  localparam int unsigned AddrBits   = 16;

  logic                clk = 1'b0;
  logic                rst_n;
  logic                frame_start;
  logic                pixel_req;
  logic                wait_req;
  cell_word_t          q_b = '0;
  logic                pixel_out;
  logic                pixel_valid;
  logic                underflow;
  logic                frame_done;
  logic [AddrBits-1:0] address_b;
  logic                read_b;

  always #5 clk = ~clk;

  cell_scanout #(
    .ROW_WORDS    (RowWords),
    .GRID_ROWS    (GridRows),
    .ADDR_BITS    (AddrBits),
    .FIFO_DEPTH   (4),
    .READ_LATENCY (2)
  ) dut (
    .i_clk          (clk),
    .i_reset        (rst_n),
    .i_frame_start  (frame_start),
    .i_pixel_req    (pixel_req),
    .o_pixel_out    (pixel_out),
    .o_pixel_valid  (pixel_valid),
    .o_underflow    (underflow),
    .o_frame_done   (frame_done),
    .o_address_b    (address_b),
    .o_read_b       (read_b),
    .i_q_b          (q_b),
    .i_wait_request (wait_req)
  );

  int unsigned tests = 0;
  int unsigned fails = 0;
  bit          data_hash = 1'b0;
  logic [31:0] data_seed = 32'h0;

  // Memory contents: a readable pattern or a seeded hash, both addressed by word.
  function automatic cell_word_t mem_word(int unsigned a);
    logic [31:0] h;
    logic [31:0] av;
    av = a;
    if (!data_hash) return {4'hF, av[15:0]};
    h = ((av + 32'd1) * 32'h9E3779B1) ^ data_seed;
    h = h ^ (h >> 13);
    return h[25:6];
  endfunction

  // Cell k of a frame is bit (WORD_BITS-1 - k%WORD_BITS) of word k/WORD_BITS.
  function automatic logic exp_bit(int unsigned k);
    cell_word_t w;
    w = mem_word(k / WORD_BITS);
    return w[WORD_BITS - 1 - (k % WORD_BITS)];
  endfunction

  // B-port memory model with a fixed two-cycle read latency.
  logic        m_acc = 1'b0;
  int unsigned m_addr = 0;
  logic        p0_v = 1'b0;
  int unsigned p0_a = 0;
  always @(posedge clk) begin
    p0_v <= m_acc;
    p0_a <= m_addr;
    q_b  <= p0_v ? mem_word(p0_a) : '0;
  end

  // Per-frame monitor; every counter restarts on a frame_start cycle.
  int unsigned pix_count = 0;
  int unsigned bit_err = 0;
  int unsigned addr_err = 0;
  int unsigned acc_count = 0;
  int unsigned first_acc = 0;
  int unsigned last_acc = 0;
  int unsigned done_cnt = 0;
  int unsigned done_err = 0;
  logic        last_final = 1'b0;
  logic        pix_hist [64];

  always @(negedge clk) begin
    m_acc  <= read_b && !wait_req;
    m_addr <= 32'(address_b);
    if (frame_start) begin
      pix_count  <= 0;
      bit_err    <= 0;
      addr_err   <= 0;
      acc_count  <= 0;
      first_acc  <= 32'hFFFF_FFFF;
      last_acc   <= 0;
      done_cnt   <= 0;
      done_err   <= 0;
      last_final <= 1'b0;
    end else begin
      if (read_b && !wait_req) begin
        if (32'(address_b) != acc_count) addr_err <= addr_err + 1;
        if (acc_count == 0) first_acc <= 32'(address_b);
        last_acc  <= 32'(address_b);
        acc_count <= acc_count + 1;
      end
      if (pixel_valid) begin
        if (pix_count < 64) pix_hist[pix_count] <= pixel_out;
        if (pixel_out !== exp_bit(pix_count)) bit_err <= bit_err + 1;
        pix_count <= pix_count + 1;
      end
      if (frame_done) begin
        done_cnt <= done_cnt + 1;
        if (!last_final) done_err <= done_err + 1;
      end else if (last_final) begin
        done_err <= done_err + 1;
      end
      last_final <= pixel_valid && (pix_count + 1 == FrameCells);
    end
  end

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_frame();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
  endtask

  task automatic run_to_done(input int unsigned req_pct, input int unsigned stall_pct,
                             input int unsigned budget);
    for (int c = 0; c < budget && done_cnt == 0; c++) begin
      pixel_req = ($urandom % 100) < req_pct;
      wait_req  = ($urandom % 100) < stall_pct;
      tick();
    end
    pixel_req = 1'b1;
    wait_req  = 1'b0;
    repeat (3) tick();
    pixel_req = 1'b0;
    tick();
  endtask

  task automatic check_frame(input string tag, input int unsigned exp_done,
                             input logic exp_uf);
    chk({tag, " cells"}, pix_count, FrameCells);
    chk({tag, " cell_bits_err"}, bit_err, 0);
    chk({tag, " addr_seq_err"}, addr_err, 0);
    chk({tag, " reads"}, acc_count, FrameWords);
    chk({tag, " last_read_addr"}, last_acc, FrameWords - 1);
    chk({tag, " frame_done_pulses"}, done_cnt, exp_done);
    chk({tag, " frame_done_timing_err"}, done_err, 0);
    chk({tag, " idle_addr"}, address_b, FrameWords - 1);
    chk({tag, " idle_read_b"}, read_b, 0);
    chk({tag, " underflow"}, underflow, exp_uf);
  endtask

  typedef struct {
    int unsigned req_pct;
    int unsigned stall_pct;
    logic [31:0] seed;
    int unsigned budget;
    int unsigned exp_done;
    logic        exp_uf;
  } rnd_vec_t;

  initial begin
    rnd_vec_t    vecs [4];
    logic [39:0] got40;
    logic [3:0]  got4;
    logic [AddrBits-1:0] a0;
    logic        r0;
    logic        stable;
    int unsigned acc0;

    vecs[0] = '{req_pct: 100, stall_pct: 0,  seed: 32'h1234_5678, budget: 2000,
                exp_done: 1, exp_uf: 1'b0};
    vecs[1] = '{req_pct: 100, stall_pct: 30, seed: 32'hCAFE_0001, budget: 2000,
                exp_done: 1, exp_uf: 1'b0};
    vecs[2] = '{req_pct: 50,  stall_pct: 60, seed: 32'h0BAD_F00D, budget: 4000,
                exp_done: 1, exp_uf: 1'b0};
    vecs[3] = '{req_pct: 25,  stall_pct: 20, seed: 32'h5EED_5EED, budget: 6000,
                exp_done: 1, exp_uf: 1'b0};

    rst_n = 1'b0;
    frame_start = 1'b0;
    pixel_req = 1'b0;
    wait_req = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    chk("reset_pixel_outputs", {pixel_out, pixel_valid, underflow, frame_done}, 0);
    chk("reset_address_b", address_b, 0);
    chk("reset_read_b", read_b, 0);
    pixel_req = 1'b1;
    tick();
    chk("idle_req_ignored", {pixel_valid, underflow}, 0);
    pixel_req = 1'b0;

    // Prefetch fill with the pattern memory, then the first two words out.
    data_hash = 1'b0;
    start_frame();
    repeat (8) tick();
    chk("fill_addr_stalls", address_b, 4);
    chk("fill_read_b_low", read_b, 0);
    chk("fill_reads", acc_count, 4);
    chk("fill_first_read", first_acc, 0);
    chk("fill_addr_seq_err", addr_err, 0);
    pixel_req = 1'b1;
    repeat (41) tick();
    for (int i = 0; i < 40; i++) got40[39-i] = pix_hist[i];
    chk("first_40_cells", got40, {20'hF0000, 20'hF0001});

    // Memory stall mid-frame.
    a0 = address_b;
    r0 = read_b;
    acc0 = acc_count;
    stable = 1'b1;
    wait_req = 1'b1;
    repeat (5) begin
      tick();
      if (address_b != a0 || (r0 && !read_b)) stable = 1'b0;
    end
    wait_req = 1'b0;
    chk("stall_holds_addr", stable, 1);
    chk("stall_no_accepts", acc_count, acc0);
    run_to_done(100, 0, 2000);
    check_frame("frame_pattern", 1, 1'b0);

    // Requests before any data: underflow is sticky until frame_start.
    start_frame();
    pixel_req = 1'b1;
    repeat (25) tick();
    pixel_req = 1'b0;
    tick();
    chk("uf_flag_set", underflow, 1);
    chk("uf_all_valid", pix_count, 25);
    for (int i = 0; i < 4; i++) got4[3-i] = pix_hist[i];
    chk("uf_first_cells", got4, 4'b0001);
    repeat (10) tick();
    chk("uf_sticky", underflow, 1);
    data_hash = 1'b1;
    data_seed = 32'hA5A5_0F0F;
    start_frame();
    chk("uf_cleared_by_start", underflow, 0);

    // Abort at address 10 with a simultaneous pixel request.
    repeat (8) tick();
    pixel_req = 1'b1;
    for (int c = 0; c < 600 && address_b != 10; c++) tick();
    chk("abort_reached_addr10", address_b, 10);
    chk("abort_no_done_before", done_cnt, 0);
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    pixel_req = 1'b0;
    chk("abort_req_dropped", pixel_valid, 0);
    chk("abort_addr_reset", address_b, 0);
    repeat (8) tick();
    chk("abort_first_read", first_acc, 0);
    run_to_done(100, 0, 2000);
    check_frame("frame_after_abort", 1, 1'b0);

    for (int v = 0; v < 4; v++) begin
      data_seed = vecs[v].seed;
      start_frame();
      repeat (8) tick();
      run_to_done(vecs[v].req_pct, vecs[v].stall_pct, vecs[v].budget);
      check_frame($sformatf("rnd%0d", v), vecs[v].exp_done, vecs[v].exp_uf);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
